// File: rtl/led_p2s_ctrl.sv
`timescale 1ns/1ps
// led_p2s_ctrl: arbitrates two LED pattern requesters and shifts the granted pattern
// MSB first over led_clk/led_d0. Define LED_P2S_RR_EN for round-robin arbitration.
module led_p2s_ctrl #(
    parameter int WIDTH = 16,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             ack0,
    output logic             ack1,
    output logic             busy,
    output logic             done,
    output logic             led_clk,
    output logic             led_d0,
    output logic             led_clr,
    output logic             led_en
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int HW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [HW-1:0] HC_LAST   = HW'(DIV - 1);
    localparam logic [HW-1:0] HC_ONE    = HW'(1);
    localparam logic [CW-1:0] BIT_TOTAL = CW'(WIDTH);
    localparam logic [CW-1:0] BIT_ONE   = CW'(1);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, DONE} state_t;

    state_t           state;
    logic [HW-1:0]    hcnt;
    logic [CW-1:0]    bcnt;
    // Bits still to send below the one currently on led_d0.
    logic [WIDTH-2:0] shreg;
    logic             sel;
    logic             win;

`ifdef LED_P2S_RR_EN
    logic last;

    // NOTE: combinational outputs get a default first so no path infers a latch.
    always_comb begin
        win = ~req0;
        if (req0 && req1) win = ~last;
    end
`else
    always_comb win = ~req0;
`endif

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state   <= IDLE;
            hcnt    <= '0;
            bcnt    <= '0;
            shreg   <= '0;
            sel     <= 1'b0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            led_clk <= 1'b1;
            led_d0  <= 1'b0;
            led_clr <= 1'b0;
            led_en  <= 1'b0;
`ifdef LED_P2S_RR_EN
            last    <= 1'b1;
`endif
        end else begin
            // NOTE: strobes default low here with <=; a later assignment in the case wins.
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            done    <= 1'b0;
            led_clr <= 1'b1;
            unique case (state)
                IDLE: begin
                    led_en  <= 1'b1;
                    led_clk <= 1'b1;
                    busy    <= 1'b0;
                    if (req0 || req1) begin
                        sel   <= win;
                        ack0  <= ~win;
                        ack1  <= win;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    shreg   <= sel ? data1[WIDTH-2:0] : data0[WIDTH-2:0];
                    led_d0  <= sel ? data1[WIDTH-1] : data0[WIDTH-1];
                    bcnt    <= BIT_TOTAL;
                    hcnt    <= '0;
                    led_clk <= 1'b0;
                    led_en  <= 1'b0;
`ifdef LED_P2S_RR_EN
                    last    <= sel;
`endif
                    state   <= SHIFT_LO;
                end
                SHIFT_LO: begin
                    if (hcnt == HC_LAST) begin
                        hcnt    <= '0;
                        led_clk <= 1'b1;
                        state   <= SHIFT_HI;
                    end else begin
                        hcnt <= hcnt + HC_ONE;
                    end
                end
                SHIFT_HI: begin
                    if (hcnt == HC_LAST) begin
                        hcnt  <= '0;
                        shreg <= shreg << 1;
                        bcnt  <= bcnt - BIT_ONE;
                        if (bcnt == BIT_ONE) begin
                            done   <= 1'b1;
                            led_en <= 1'b1;
                            led_d0 <= 1'b0;
                            state  <= DONE;
                        end else begin
                            led_clk <= 1'b0;
                            led_d0  <= shreg[WIDTH-2];
                            state   <= SHIFT_LO;
                        end
                    end else begin
                        hcnt <= hcnt + HC_ONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_p2s_ctrl.sv
`timescale 1ns/1ps
// tb_led_p2s_ctrl: directed checks of led_p2s_ctrl using a DIV=1 instance (dut_a)
// and a DIV=3 instance (dut_b) sharing the same request inputs.
module tb_led_p2s_ctrl;

    localparam int W = 16;

    logic         clk;
    logic         clear;
    logic         req0, req1;
    logic [W-1:0] data0, data1;

    logic ack0_a, ack1_a, busy_a, done_a, led_clk_a, led_d0_a, led_clr_a, led_en_a;
    logic ack0_b, ack1_b, busy_b, done_b, led_clk_b, led_d0_b, led_clr_b, led_en_b;

    // Selects which instance the m_* probes observe.
    logic dsel;
    logic m_ack0, m_ack1, m_busy, m_done, m_led_clk, m_led_d0, m_led_clr, m_led_en;
    assign m_ack0    = dsel ? ack0_b    : ack0_a;
    assign m_ack1    = dsel ? ack1_b    : ack1_a;
    assign m_busy    = dsel ? busy_b    : busy_a;
    assign m_done    = dsel ? done_b    : done_a;
    assign m_led_clk = dsel ? led_clk_b : led_clk_a;
    assign m_led_d0  = dsel ? led_d0_b  : led_d0_a;
    assign m_led_clr = dsel ? led_clr_b : led_clr_a;
    assign m_led_en  = dsel ? led_en_b  : led_en_a;

    led_p2s_ctrl #(.WIDTH(W), .DIV(1)) dut_a (
        .clk(clk), .clear(clear),
        .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .ack0(ack0_a), .ack1(ack1_a), .busy(busy_a), .done(done_a),
        .led_clk(led_clk_a), .led_d0(led_d0_a), .led_clr(led_clr_a), .led_en(led_en_a)
    );

    led_p2s_ctrl #(.WIDTH(W), .DIV(3)) dut_b (
        .clk(clk), .clear(clear),
        .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .ack0(ack0_b), .ack1(ack1_b), .busy(busy_b), .done(done_b),
        .led_clk(led_clk_b), .led_d0(led_d0_b), .led_clr(led_clr_b), .led_en(led_en_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total, bad;

    typedef struct {
        logic         who;
        logic [W-1:0] pat;
        logic [W-1:0] exp_bits;
        int           exp_busy;
    } vec_t;

    vec_t vecs [5];

    // Per-transfer observations filled by run_xfer.
    logic [W-1:0] r_bits;
    int r_rises, r_busy, r_ack, r_wrong_ack, r_done_at, r_viol;
    int r_lo_min, r_lo_max, r_en_hi, r_fall1;
    bit r_timeout;

    int n_ack, n_lo, n_enlo, n_busy, n_done, n_gr, n_both, n_r;
    logic [2:0] order, exp_order;
    logic pclk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    // Raise one request, drop it on its ack, and observe the transfer up to done.
    task automatic run_xfer(input logic who, input logic [W-1:0] pat, input int poke_at);
        int  cyc, ack_cyc, rel, lo_run;
        bit  seen_ack, prev_clk, prev_d0;
        r_bits = '0; r_rises = 0; r_busy = 0; r_ack = 0; r_wrong_ack = 0; r_done_at = 0;
        r_viol = 0; r_lo_min = 1000; r_lo_max = 0; r_en_hi = 0; r_fall1 = 0; r_timeout = 0;
        @(negedge clk);
        if (who) begin req1 = 1'b1; data1 = pat; end
        else     begin req0 = 1'b1; data0 = pat; end
        cyc = 0; ack_cyc = 0; seen_ack = 0; lo_run = 0;
        prev_clk = m_led_clk; prev_d0 = m_led_d0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (cyc > 400) begin r_timeout = 1; break; end
            if (who ? m_ack1 : m_ack0) begin
                r_ack++;
                if (!seen_ack) ack_cyc = cyc;
                seen_ack = 1;
                if (who) req1 = 1'b0; else req0 = 1'b0;
            end
            if (who ? m_ack0 : m_ack1) r_wrong_ack++;
            rel = seen_ack ? cyc - ack_cyc + 1 : 0;
            if (m_busy) r_busy++;
            if (m_busy && !m_ack0 && !m_ack1 && !m_done && m_led_en) r_en_hi++;
            if (!m_led_clk && prev_clk && r_fall1 == 0) r_fall1 = rel;
            if (m_led_d0 !== prev_d0 && !(prev_clk && !m_led_clk) && !m_done) r_viol++;
            if (!m_led_clk) lo_run++;
            else if (!prev_clk) begin
                r_bits = {r_bits[W-2:0], m_led_d0};
                r_rises++;
                if (lo_run < r_lo_min) r_lo_min = lo_run;
                if (lo_run > r_lo_max) r_lo_max = lo_run;
                lo_run = 0;
            end
            if (poke_at > 0 && seen_ack && rel == poke_at) begin
                data0 = ~pat;
                req1  = 1'b1;
                data1 = 16'h3C5A;
            end
            if (m_done) begin r_done_at = rel; break; end
            prev_clk = m_led_clk;
            prev_d0  = m_led_d0;
        end
    endtask

    task automatic check_xfer(input string nm, input logic [W-1:0] exp_bits,
                              input int exp_len, input int exp_lo);
        check({nm, "_timeout"},    r_timeout,   0);
        check({nm, "_ack"},        r_ack,       1);
        check({nm, "_other_ack"},  r_wrong_ack, 0);
        check({nm, "_rises"},      r_rises,     W);
        check({nm, "_bits"},       r_bits,      exp_bits);
        check({nm, "_busy"},       r_busy,      exp_len);
        check({nm, "_done_at"},    r_done_at,   exp_len);
        check({nm, "_first_fall"}, r_fall1,     2);
        check({nm, "_d0_stable"},  r_viol,      0);
        check({nm, "_en_low"},     r_en_hi,     0);
        check({nm, "_lo_min"},     r_lo_min,    exp_lo);
        check({nm, "_lo_max"},     r_lo_max,    exp_lo);
    endtask

    task automatic drain(input string nm);
        int c;
        c = 0;
        while (m_busy && c < 500) begin
            @(negedge clk);
            c++;
        end
        check({nm, "_drain"}, m_busy, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
        clear = 1'b1;
    endtask

    initial begin
        total = 0; bad = 0; dsel = 1'b0;
        req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
        vecs[0] = '{1'b0, 16'hA5C3, 16'hA5C3, 34};
        vecs[1] = '{1'b1, 16'h0001, 16'h0001, 34};
        vecs[2] = '{1'b0, 16'h8000, 16'h8000, 34};
        vecs[3] = '{1'b1, 16'hFFFF, 16'hFFFF, 34};
        vecs[4] = '{1'b0, 16'h0000, 16'h0000, 34};
`ifdef LED_P2S_RR_EN
        exp_order = 3'b010;
`else
        exp_order = 3'b000;
`endif

        // Start high so the drop to 0 is a real edge for the async reset.
        clear = 1'b1;
        #2 clear = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_led_clk", m_led_clk, 1);
        check("rst_led_d0",  m_led_d0,  0);
        check("rst_led_clr", m_led_clr, 0);
        check("rst_led_en",  m_led_en,  0);
        check("rst_acks",    {m_ack0, m_ack1}, 0);
        check("rst_busy",    m_busy, 0);
        check("rst_done",    m_done, 0);
        clear = 1'b1;
        @(negedge clk);
        check("rel_led_clr", m_led_clr, 1);
        check("rel_led_en",  m_led_en,  1);

        // Idle with no request, plus a request pulse that never spans a clock edge.
        n_ack = 0; n_lo = 0; n_enlo = 0; n_busy = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 4) begin req0 = 1'b1; #1; req0 = 1'b0; end
            @(negedge clk);
            if (m_ack0 || m_ack1) n_ack++;
            if (!m_led_clk) n_lo++;
            if (!m_led_en) n_enlo++;
            if (m_busy) n_busy++;
        end
        check("idle_acks",    n_ack,  0);
        check("idle_clk_low", n_lo,   0);
        check("idle_en_low",  n_enlo, 0);
        check("idle_busy",    n_busy, 0);

        for (int i = 0; i < 5; i++) begin
            run_xfer(vecs[i].who, vecs[i].pat, 0);
            check_xfer($sformatf("vec%0d", i), vecs[i].exp_bits, vecs[i].exp_busy, 1);
        end

        // req1 and a data0 change arrive mid-transfer; ack1 must wait for IDLE then LOAD.
        run_xfer(1'b0, 16'h5A96, 6);
        check_xfer("hold", 16'h5A96, 34, 1);
        @(negedge clk);
        check("hold_gap_ack1", m_ack1, 0);
        check("hold_gap_busy", m_busy, 0);
        @(negedge clk);
        check("hold_ack1", m_ack1, 1);
        check("hold_ack0", m_ack0, 0);
        req1 = 1'b0;
        drain("hold");

        // Both requests held from reset: grant order depends on arbitration mode.
        @(negedge clk);
        clear = 1'b0; req0 = 1'b1; req1 = 1'b1; data0 = 16'h1234; data1 = 16'h4321;
        @(negedge clk);
        clear = 1'b1;
        n_gr = 0; n_both = 0; order = '0;
        for (int c = 0; c < 400 && n_gr < 3; c++) begin
            @(negedge clk);
            if (m_ack0 && m_ack1) n_both++;
            if (m_ack1) begin order[n_gr] = 1'b1; n_gr++; end
            else if (m_ack0) n_gr++;
        end
        req0 = 1'b0; req1 = 1'b0;
        check("grant_count", n_gr, 3);
        check("grant_both",  n_both, 0);
        check("grant_order", order, exp_order);
        drain("grant");

        // Abort after five bits, then a clean full transfer.
        @(negedge clk);
        req0 = 1'b1; data0 = 16'hF0F0;
        n_r = 0; pclk = m_led_clk;
        for (int c = 0; c < 100 && n_r < 5; c++) begin
            @(negedge clk);
            if (m_ack0) req0 = 1'b0;
            if (m_led_clk && !pclk) n_r++;
            pclk = m_led_clk;
        end
        check("abort_pre_rises", n_r, 5);
        clear = 1'b0;
        #1;
        check("abort_led_clk", m_led_clk, 1);
        check("abort_led_clr", m_led_clr, 0);
        check("abort_busy",    m_busy, 0);
        check("abort_done",    m_done, 0);
        check("abort_led_en",  m_led_en, 0);
        @(negedge clk);
        clear = 1'b1;
        n_done = 0; n_busy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m_done) n_done++;
            if (m_busy) n_busy++;
        end
        check("abort_no_done",   n_done, 0);
        check("abort_stay_idle", n_busy, 0);
        run_xfer(1'b0, 16'hC3A5, 0);
        check_xfer("after_abort", 16'hC3A5, 34, 1);

        // Divided rate on the DIV=3 instance, starting from a clean reset.
        do_reset();
        dsel = 1'b1;
        run_xfer(1'b0, 16'h9B6D, 0);
        check_xfer("div3", 16'h9B6D, 98, 3);
        drain("div3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
